// File: rtl/sign_mag_addsub_seq_amisha_pkg.sv
// Shared encodings for the sequential sign-magnitude add/subtract unit.
package sign_mag_addsub_seq_amisha_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCmp  = 2'd1,
    StCalc = 2'd2,
    StDone = 2'd3
  } state_e;

  localparam logic OpAdd = 1'b0;
  localparam logic OpSub = 1'b1;

endpackage

// File: rtl/sign_mag_core_amisha.sv
// Combinational sign-magnitude adder on operands already ordered by magnitude.
module sign_mag_core_amisha #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] big_i,
  input  logic [N-1:0] small_i,
  output logic [N-1:0] sum_o,
  output logic         ovf_o
);

  localparam int unsigned M = N - 1;

  logic [M:0] mag;

  always_comb begin
    mag   = '0;
    ovf_o = 1'b0;
    if (big_i[N-1] == small_i[N-1]) begin
      mag   = {1'b0, big_i[M-1:0]} + {1'b0, small_i[M-1:0]};
      ovf_o = mag[M];
    end else begin
      mag = {1'b0, big_i[M-1:0]} - {1'b0, small_i[M-1:0]};
    end
    // A zero magnitude (including an overflow wrap) is always reported as +0.
    sum_o = {big_i[N-1] & (mag[M-1:0] != '0), mag[M-1:0]};
  end

endmodule

// File: rtl/sign_mag_addsub_seq_amisha.sv
// Sequential sign-magnitude add/subtract with valid/ready handshakes and fixed latency.
module sign_mag_addsub_seq_amisha
  import sign_mag_addsub_seq_amisha_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk_amisha,
  input  logic         rst_n_amisha,
  input  logic         in_valid_amisha,
  output logic         in_ready_amisha,
  input  logic         op_amisha,
  input  logic [N-1:0] a_amisha,
  input  logic [N-1:0] b_amisha,
  output logic         out_valid_amisha,
  input  logic         out_ready_amisha,
  output logic [N-1:0] sum_amisha,
  output logic         ovf_amisha
);

  state_e state_q, state_d;

  logic [N-1:0] a_q, b_q;
  logic [N-1:0] big_q, small_q;
  logic [N-1:0] sum_q;
  logic         ovf_q;

  logic         accept;
  logic         b_sign;
  logic [N-1:0] norm_a, norm_b;
  logic [N-1:0] core_sum;
  logic         core_ovf;

  assign in_ready_amisha  = (state_q == StIdle);
  assign out_valid_amisha = (state_q == StDone);
  assign sum_amisha       = sum_q;
  assign ovf_amisha       = ovf_q;
  assign accept           = in_valid_amisha & in_ready_amisha;

  always_comb begin
    b_sign = b_amisha[N-1];
    unique case (op_amisha)
      OpAdd:   b_sign = b_amisha[N-1];
      OpSub:   b_sign = ~b_amisha[N-1];
      default: b_sign = b_amisha[N-1];
    endcase
  end

  // Fold -0 into +0 so the sign comparison in the core only sees real signs.
  assign norm_a = {a_q[N-1] & (a_q[N-2:0] != '0), a_q[N-2:0]};
  assign norm_b = {b_q[N-1] & (b_q[N-2:0] != '0), b_q[N-2:0]};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCmp;
      StCmp:   state_d = StCalc;
      StCalc:  state_d = StDone;
      StDone:  if (out_ready_amisha) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      big_q   <= '0;
      small_q <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q <= a_amisha;
        b_q <= {b_sign, b_amisha[N-2:0]};
      end
      if (state_q == StCmp) begin
        if (norm_b[N-2:0] > norm_a[N-2:0]) begin
          big_q   <= norm_b;
          small_q <= norm_a;
        end else begin
          big_q   <= norm_a;
          small_q <= norm_b;
        end
      end
      if (state_q == StCalc) begin
        sum_q <= core_sum;
        ovf_q <= core_ovf;
      end
    end
  end

  sign_mag_core_amisha #(
    .N(N)
  ) u_core (
    .big_i  (big_q),
    .small_i(small_q),
    .sum_o  (core_sum),
    .ovf_o  (core_ovf)
  );

endmodule
